watch_mode_ctrl: RTL and testbench

- Top-level sequencer for the watch.
- Debounces the raw front-panel buttons and owns the mode register (`state`) and the per-mode sub-state (`flag`) that drive the clock, alarm, timer and stopwatch datapaths.
- Muxes the four datapaths' BCD digits onto the single 4-digit display, blinking the digit being edited.
- Arbitrates the one speaker between ringing sources and acknowledges rings.

---
 rtl/watch_pkg.sv | 57 +++++
 rtl/btn_debounce.sv | 41 ++++
 rtl/watch_mode_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_watch_mode_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch mode controller.
package watch_pkg;

  typedef enum logic [1:0] {
    ModeClock     = 2'd0,
    ModeAlarm     = 2'd1,
    ModeTimer     = 2'd2,
    ModeStopwatch = 2'd3
  } mode_t;

  typedef enum logic [3:0] {
    FlagRun   = 4'd0,
    FlagPause = 4'd1,
    FlagClear = 4'd2,
    FlagEdit0 = 4'd3,
    FlagEdit1 = 4'd4,
    FlagEdit2 = 4'd5,
    FlagEdit3 = 4'd6,
    FlagRing  = 4'd7
  } flag_t;

  // Bit positions of the buttons this block acts on
  localparam int unsigned BTN_MODE  = 0;
  localparam int unsigned BTN_EDIT  = 1;
  localparam int unsigned BTN_START = 2;
  localparam int unsigned BTN_CLEAR = 7;

  // Ring priority, highest first: entry i lives at bits [2i+1:2i]
  localparam logic [7:0] RING_PRIO = {2'd0, 2'd3, 2'd2, 2'd1};

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Highest-priority requesting source; only meaningful when req is non-zero
  function automatic logic [1:0] ring_winner(input logic [3:0] req);
    logic [1:0] win;
    win = 2'd0;
    // Walk from lowest to highest priority so the highest one wins last
    for (int i = 3; i >= 0; i--) begin
      if (req[RING_PRIO[2*i +: 2]]) begin
        win = RING_PRIO[2*i +: 2];
      end
    end
    return win;
  endfunction

  function automatic logic is_edit(input flag_t f);
    return (f == FlagEdit0) || (f == FlagEdit1) || (f == FlagEdit2) || (f == FlagEdit3);
  endfunction

  // EDIT0..EDIT3 are encoded 3..6, so the low two bits plus one give the digit
  function automatic logic [1:0] edit_digit(input flag_t f);
    logic [3:0] v;
    v = f;
    return v[1:0] + 2'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one active-low button: emits a single-cycle press pulse once
// the button has been stably pressed for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Saturating press counter; the pulse is raised together with saturation
  always_comb begin
    cnt_d   = '0;
    press_d = 1'b0;
    if (!btn_n_i) begin
      cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      press_d = (cnt_q == CntMax - 1'b1);
    end
  end

  // Counter and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch top-level sequencer: debounced buttons, mode register and per-mode
// sub-state, display mux with edit-digit blink, speaker arbitration and ring ack.
// Optional macro WATCH_AUTO_RETURN_EN: leave EDIT after IDLE_TIMEOUT idle cycles.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_CYCLES    = 8,
  parameter int unsigned TONE_DIV        = 3,
  parameter int unsigned IDLE_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  btn,
  output logic [3:0]  state,
  output logic [3:0]  flag,
  input  logic [63:0] disp_in,
  output logic [15:0] disp_out,
  input  logic [3:0]  spk_req,
  output logic [3:0]  ring_ack,
  output logic        out_speaker
);

  localparam int unsigned ToneW  = $clog2(TONE_DIV + 1);
  localparam logic [ToneW-1:0] ToneLast = ToneW'(TONE_DIV - 1);
  localparam int unsigned BlinkW = $clog2(2 * BLINK_CYCLES);
  localparam logic [BlinkW-1:0] BlinkHalf = BlinkW'(BLINK_CYCLES);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(2 * BLINK_CYCLES - 1);

  logic press_mode, press_edit, press_start, press_clear, any_press;

  mode_t            mode_q, mode_d;
  flag_t            flag_q [4];
  flag_t            flag_d [4];
  flag_t            cur_flag, next_flag, flag_shown;
  logic             mode_step;

  logic             ring_valid;
  logic [1:0]       ring_win;
  logic [ToneW-1:0] tone_q, tone_d;
  logic             spk_q, spk_d;
  logic [3:0]       ack_q, ack_d;

  logic [BlinkW-1:0] blink_q, blink_d;
  logic [15:0]       disp_q, disp_d;

  // Digit-increment buttons are handled by the datapaths, not here
  logic unused_digit_btns;
  assign unused_digit_btns = ^btn[6:3];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (btn[BTN_MODE]),
    .press_o (press_mode)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_edit (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (btn[BTN_EDIT]),
    .press_o (press_edit)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (btn[BTN_START]),
    .press_o (press_start)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (btn[BTN_CLEAR]),
    .press_o (press_clear)
  );

  assign any_press  = press_mode | press_edit | press_start | press_clear;
  assign ring_valid = |spk_req;
  assign ring_win   = ring_winner(spk_req);
  assign cur_flag   = flag_q[mode_q];
  assign flag_shown = spk_req[mode_q] ? FlagRing : cur_flag;

`ifdef WATCH_AUTO_RETURN_EN
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT);
  logic [IdleW-1:0] idle_q, idle_d;

  // Idle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = ^IDLE_TIMEOUT;
`endif

  // Tone generator: square wave while any source rings, silent otherwise
  always_comb begin
    tone_d = '0;
    spk_d  = 1'b0;
    if (ring_valid) begin
      if (tone_q == ToneLast) begin
        tone_d = '0;
        spk_d  = ~spk_q;
      end else begin
        tone_d = tone_q + 1'b1;
        spk_d  = spk_q;
      end
    end
  end

  // Any press while ringing acknowledges the winning source only
  always_comb begin
    ack_d = '0;
    if (ring_valid && any_press) begin
      ack_d = 4'b0001 << ring_win;
    end
  end

  // Flag FSM of the current mode plus mode stepping; one action per cycle
  always_comb begin
    flag_d    = flag_q;
    mode_d    = mode_q;
    next_flag = cur_flag;
    mode_step = 1'b0;
`ifdef WATCH_AUTO_RETURN_EN
    idle_d    = '0;
`endif
    if (cur_flag == FlagClear) begin
      next_flag = FlagPause;
    end else if (!ring_valid) begin
      // Presses during a ring were consumed by the acknowledge
      if (press_clear) begin
        if (cur_flag == FlagPause) next_flag = FlagClear;
      end else if (press_start) begin
        case (cur_flag)
          FlagRun:                                    next_flag = FlagPause;
          FlagPause:                                  next_flag = FlagRun;
          FlagEdit0, FlagEdit1, FlagEdit2, FlagEdit3: next_flag = FlagPause;
          default:                                    next_flag = cur_flag;
        endcase
      end else if (press_edit) begin
        case (cur_flag)
          FlagPause: next_flag = FlagEdit0;
          FlagEdit0: next_flag = FlagEdit1;
          FlagEdit1: next_flag = FlagEdit2;
          FlagEdit2: next_flag = FlagEdit3;
          FlagEdit3: next_flag = FlagPause;
          default:   next_flag = cur_flag;
        endcase
      end else if (press_mode) begin
        mode_step = (cur_flag == FlagRun) || (cur_flag == FlagPause);
      end
    end
`ifdef WATCH_AUTO_RETURN_EN
    if (!any_press && is_edit(cur_flag)) begin
      if (idle_q == IdleLast) begin
        next_flag = FlagPause;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
    flag_d[mode_q] = next_flag;
    if (mode_step) mode_d = mode_t'(mode_q + 2'd1);
  end

  // Free-running blink phase counter
  always_comb begin
    blink_d = (blink_q == BlinkLast) ? '0 : blink_q + 1'b1;
  end

  // Display mux with the edited digit blanked during the odd blink half
  always_comb begin
    disp_d = disp_in[{mode_q, 4'b0000} +: 16];
    if (is_edit(flag_shown) && (blink_q >= BlinkHalf)) begin
      disp_d[{edit_digit(flag_shown), 2'b00} +: 4] = BLANK_DIGIT;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= ModeClock;
      flag_q[0] <= FlagRun;
      flag_q[1] <= FlagPause;
      flag_q[2] <= FlagPause;
      flag_q[3] <= FlagPause;
      tone_q    <= '0;
      spk_q     <= 1'b0;
      ack_q     <= '0;
      blink_q   <= '0;
      disp_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      flag_q    <= flag_d;
      tone_q    <= tone_d;
      spk_q     <= spk_d;
      ack_q     <= ack_d;
      blink_q   <= blink_d;
      disp_q    <= disp_d;
    end
  end

  assign state       = {2'b00, mode_q};
  assign flag        = flag_shown;
  assign disp_out    = disp_q;
  assign ring_ack    = ack_q;
  assign out_speaker = spk_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Scoreboard bench for watch_mode_ctrl: stimulus pushes timed expectations,
// a negedge monitor pops and compares them.
module tb_watch_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  btn;
  logic [3:0]  state, flag;
  logic [63:0] disp_in;
  logic [15:0] disp_out;
  logic [3:0]  spk_req, ring_ack;
  logic        out_speaker;

  watch_mode_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .state       (state),
    .flag        (flag),
    .disp_in     (disp_in),
    .disp_out    (disp_out),
    .spk_req     (spk_req),
    .ring_ack    (ring_ack),
    .out_speaker (out_speaker)
  );

  always #5 clk = ~clk;

  localparam int KState = 0, KFlag = 1, KDisp = 2, KAck = 3, KSpk = 4;

  int          sb_due [$];
  int          sb_kind [$];
  logic [15:0] sb_exp [$];
  string       sb_name [$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int m_blk;

  always @(posedge clk) cyc <= cyc + 1;

  // Blink phase model: free-running 0..15 from reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_blk <= 0;
    else        m_blk <= (m_blk == 15) ? 0 : m_blk + 1;
  end

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      KState:  return {12'h000, state};
      KFlag:   return {12'h000, flag};
      KDisp:   return disp_out;
      KAck:    return {12'h000, ring_ack};
      default: return {15'h0000, out_speaker};
    endcase
  endfunction

  task automatic expect_at(input int dly, input int kind, input logic [15:0] exp,
                           input string name);
    sb_due.push_back(cyc + dly);
    sb_kind.push_back(kind);
    sb_exp.push_back(exp);
    sb_name.push_back(name);
  endtask

  // Monitor: compare every expectation due in the current cycle
  initial begin
    logic [15:0] act;
    forever begin
      @(negedge clk);
      for (int i = sb_due.size() - 1; i >= 0; i--) begin
        if (sb_due[i] <= cyc) begin
          act = actual(sb_kind[i]);
          n_checks++;
          if (sb_due[i] < cyc || act !== sb_exp[i]) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                     sb_name[i], act, sb_exp[i], cyc);
          end
          sb_due.delete(i);
          sb_kind.delete(i);
          sb_exp.delete(i);
          sb_name.delete(i);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the buttons long enough for one accepted press, release, and return
  // on the cycle in which the press has taken effect
  task automatic press(input logic [7:0] mask);
    btn = ~mask;
    tick(4);
    btn = 8'hFF;
    tick(1);
  endtask

  initial begin
    logic [15:0] e;
    rst_n   = 1'b0;
    btn     = 8'hFF;
    spk_req = 4'b0000;
    disp_in = 64'h9876_5432_1098_7654;
    tick(3);
    expect_at(0, KState, 16'd0, "rst_state");
    expect_at(0, KFlag,  16'd0, "rst_flag");
    expect_at(0, KDisp,  16'd0, "rst_disp");
    expect_at(0, KAck,   16'd0, "rst_ack");
    expect_at(0, KSpk,   16'd0, "rst_spk");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Debounce: long hold of MODE steps once, on the fourth stable cycle
    btn[0] = 1'b0;
    expect_at(4,  KState, 16'd0, "mode_before_accept");
    expect_at(5,  KState, 16'd1, "mode_accept");
    expect_at(5,  KFlag,  16'd1, "alarm_flag_pause");
    expect_at(10, KState, 16'd1, "mode_no_repeat");
    tick(10);
    btn = 8'hFF;
    expect_at(2, KState, 16'd1, "mode_after_release");
    tick(3);
    press(8'h01);
    expect_at(0, KState, 16'd2, "mode_timer");
    expect_at(0, KFlag,  16'd1, "timer_flag_pause");
    expect_at(1, KDisp,  16'h5432, "disp_timer");

    // EDIT walk through all digits with blink check on digit 1
    press(8'h02);
    expect_at(0, KFlag, 16'd3, "edit0");
    press(8'h02);
    expect_at(0, KFlag, 16'd4, "edit1");
    for (int k = 0; k < 20; k++) begin
      e = 16'h5432;
      if (m_blk >= 8) e[7:4] = 4'hF;
      expect_at(1, KDisp, e, "disp_blink");
      tick(1);
    end
    press(8'h02);
    expect_at(0, KFlag, 16'd5, "edit2");
    press(8'h02);
    expect_at(0, KFlag, 16'd6, "edit3");
    press(8'h02);
    expect_at(0, KFlag, 16'd1, "edit_wrap_pause");

    // MODE ignored in EDIT; START leaves EDIT, then MODE advances
    press(8'h02);
    press(8'h02);
    press(8'h02);
    expect_at(0, KFlag, 16'd5, "edit2_again");
    press(8'h01);
    expect_at(0, KState, 16'd2, "mode_ignored_edit");
    expect_at(0, KFlag,  16'd5, "flag_kept_edit");
    press(8'h04);
    expect_at(0, KFlag, 16'd1, "start_exit_edit");
    press(8'h01);
    expect_at(0, KState, 16'd3, "mode_stopwatch");
    expect_at(0, KFlag,  16'd1, "sw_flag_pause");

    // CLEAR beats START when pressed together
    press(8'h84);
    expect_at(0, KFlag, 16'd2, "clear_pulse");
    expect_at(1, KFlag, 16'd1, "clear_to_pause");
    tick(2);

    // Ringing: ALARM wins over TIMER, tone toggles every 3 cycles
    spk_req = 4'b0110;
    expect_at(0, KFlag, 16'd1, "flag_other_ring");
    for (int k = 0; k < 12; k++) begin
      expect_at(k, KSpk, 16'((k / 3) % 2), "tone");
    end
    tick(12);
    press(8'h04);
    expect_at(0, KAck,   16'b0010, "ack_alarm");
    expect_at(1, KAck,   16'b0000, "ack_one_cycle");
    expect_at(0, KFlag,  16'd1,    "flag_press_consumed");
    expect_at(0, KState, 16'd3,    "state_press_consumed");
    tick(2);
    press(8'h06);
    expect_at(0, KAck,  16'b0010, "ack_multi_btn");
    expect_at(1, KAck,  16'b0000, "ack_multi_single");
    expect_at(0, KFlag, 16'd1,    "flag_multi_consumed");
    tick(2);
    spk_req = 4'b1000;
    expect_at(0, KFlag, 16'd7, "flag_ring_own");
    press(8'h01);
    expect_at(0, KAck,   16'b1000, "ack_stopwatch");
    expect_at(0, KState, 16'd3,    "mode_consumed");
    tick(2);
    spk_req = 4'b1001;
    press(8'h80);
    expect_at(0, KAck, 16'b1000, "ack_prio_3_over_0");
    spk_req = 4'b0000;
    expect_at(0, KFlag, 16'd1, "clear_consumed");
    expect_at(1, KSpk,  16'd0, "spk_silent");
    tick(3);

    // Asynchronous reset in the middle of a ring while editing
    press(8'h02);
    press(8'h02);
    expect_at(0, KFlag, 16'd4, "edit1_before_rst");
    spk_req = 4'b0010;
    tick(4);
    expect_at(0, KSpk, 16'd1, "spk_before_rst");
    press(8'h02);
    #1;
    rst_n = 1'b0;
    expect_at(0, KState, 16'd0, "async_rst_state");
    expect_at(0, KAck,   16'd0, "async_rst_ack");
    expect_at(0, KSpk,   16'd0, "async_rst_spk");
    expect_at(0, KDisp,  16'd0, "async_rst_disp");
    tick(2);
    rst_n   = 1'b1;
    spk_req = 4'b0000;
    expect_at(0, KFlag, 16'd0, "rst_clock_run");
    press(8'h01);
    expect_at(0, KState, 16'd1, "rst_mode1");
    expect_at(0, KFlag,  16'd1, "rst_alarm_pause");
    press(8'h01);
    expect_at(0, KState, 16'd2, "rst_mode2");
    expect_at(0, KFlag,  16'd1, "rst_timer_pause");
    press(8'h01);
    expect_at(0, KState, 16'd3, "rst_mode3");
    expect_at(0, KFlag,  16'd1, "rst_sw_pause");
    press(8'h01);
    expect_at(0, KState, 16'd0, "rst_mode_wrap");
    expect_at(0, KFlag,  16'd0, "rst_wrap_run");

    tick(2);
    for (int k = 0; k < 20 && sb_due.size() != 0; k++) tick(1);
    if (sb_due.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_due.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
